// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_ctrl
//  Description : Two-road intersection lamp sequencer with four 3-bit
//                configuration registers written from the spi_sclk domain.
//                The write strobe is synchronized into clk, edge-detected
//                and applied once per rising edge of spi_wen.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl #(
    parameter int TICK_DIV     = 1000000,
    parameter int ALLRED_TICKS = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       spi_wen,
    input  logic [1:0] spi_addr,
    input  logic [2:0] spi_data,
    output logic       main_r,
    output logic       main_y,
    output logic       main_g,
    output logic       side_r,
    output logic       side_y,
    output logic       side_g,
    output logic [2:0] state,
    output logic       wr_strobe
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0]    ALLRED_DUR = 4'(ALLRED_TICKS);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_M_GREEN  = 3'd1;
    localparam logic [2:0] S_M_YELLOW = 3'd2;
    localparam logic [2:0] S_M_ALLRED = 3'd3;
    localparam logic [2:0] S_S_GREEN  = 3'd4;
    localparam logic [2:0] S_S_YELLOW = 3'd5;
    localparam logic [2:0] S_S_ALLRED = 3'd6;
    localparam logic [2:0] S_BLINK    = 3'd7;

    // Lamp vector order: {main_r, main_y, main_g, side_r, side_y, side_g}
    localparam logic [5:0] LAMPS_ALLRED = 6'b100100;

    // Register file and write synchronizer
    logic          wen_m_q, wen_s_q, wen_d_q;
    logic [2:0]    ctrl_q, mgrn_q, sgrn_q, yel_q;
    logic          strobe;

    // Sequencer state
    logic [2:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    timer_q, timer_d;
    logic          blink_q, blink_d;
    logic [5:0]    lamp_q, lamp_d;
    logic          tick;
    logic          state_change;
    logic          ctrl_run, ctrl_blink, ctrl_force;

    // A stored duration of zero stands for the longest dwell, 8 ticks
    function automatic logic [3:0] dur_ticks(input logic [2:0] v);
        return (v == 3'd0) ? 4'd8 : {1'b0, v};
    endfunction

    assign strobe     = wen_s_q & ~wen_d_q;
    assign ctrl_run   = ctrl_q[0];
    assign ctrl_blink = ctrl_q[1];
    assign ctrl_force = ctrl_q[2];

    // Bring the write strobe into clk: two-flop synchronizer plus edge-detect delay
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wen_m_q <= 1'b0;
            wen_s_q <= 1'b0;
            wen_d_q <= 1'b0;
        end else begin
            wen_m_q <= spi_wen;
            wen_s_q <= wen_m_q;
            wen_d_q <= wen_s_q;
        end
    end

    // Capture addr/data on the strobe; upstream holds them stable long enough
    // that they are settled by the time the synchronized strobe arrives
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ctrl_q <= 3'b000;
            mgrn_q <= 3'd5;
            sgrn_q <= 3'd3;
            yel_q  <= 3'd2;
        end else if (strobe) begin
            case (spi_addr)
                2'd0:    ctrl_q <= spi_data;
                2'd1:    mgrn_q <= spi_data;
                2'd2:    sgrn_q <= spi_data;
                default: yel_q  <= spi_data;
            endcase
        end
    end

    assign tick         = (presc_q == PRESC_MAX);
    assign state_change = (state_d != state_q);

    // Next-state: overrides from live CTRL first, then the timed cycle
    always_comb begin
        state_d = state_q;
        if (ctrl_force || !ctrl_run) begin
            state_d = S_IDLE;
        end else if (ctrl_blink) begin
            state_d = S_BLINK;
        end else begin
            case (state_q)
                S_IDLE:     state_d = S_M_GREEN;
                S_BLINK:    state_d = S_IDLE;
                S_M_GREEN:  if (tick && timer_q == 4'd1) state_d = S_M_YELLOW;
                S_M_YELLOW: if (tick && timer_q == 4'd1) state_d = S_M_ALLRED;
                S_M_ALLRED: if (tick && timer_q == 4'd1) state_d = S_S_GREEN;
                S_S_GREEN:  if (tick && timer_q == 4'd1) state_d = S_S_YELLOW;
                S_S_YELLOW: if (tick && timer_q == 4'd1) state_d = S_S_ALLRED;
                S_S_ALLRED: if (tick && timer_q == 4'd1) state_d = S_M_GREEN;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Prescaler restarts on each state change so dwell is an exact tick multiple;
    // timer samples the duration only on entry; blink phase starts lit
    always_comb begin
        presc_d = (state_change || tick) ? '0 : presc_q + 1'b1;

        timer_d = timer_q;
        if (state_change) begin
            case (state_d)
                S_M_GREEN:              timer_d = dur_ticks(mgrn_q);
                S_S_GREEN:              timer_d = dur_ticks(sgrn_q);
                S_M_YELLOW, S_S_YELLOW: timer_d = dur_ticks(yel_q);
                S_M_ALLRED, S_S_ALLRED: timer_d = ALLRED_DUR;
                default:                timer_d = 4'd0;
            endcase
        end else if (tick && timer_q != 4'd0) begin
            timer_d = timer_q - 4'd1;
        end

        blink_d = blink_q;
        if (state_change)
            blink_d = 1'b1;
        else if (tick)
            blink_d = ~blink_q;
    end

    // Lamps decoded from the next state so they switch together with state
    always_comb begin
        lamp_d = LAMPS_ALLRED;
        case (state_d)
            S_M_GREEN:  lamp_d = 6'b001100;
            S_M_YELLOW: lamp_d = 6'b010100;
            S_S_GREEN:  lamp_d = 6'b100001;
            S_S_YELLOW: lamp_d = 6'b100010;
            S_BLINK:    lamp_d = {1'b0, blink_d, 1'b0, 1'b0, blink_d, 1'b0};
            default:    lamp_d = LAMPS_ALLRED;
        endcase
    end

    // Sequencer registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            timer_q <= 4'd0;
            blink_q <= 1'b0;
            lamp_q  <= LAMPS_ALLRED;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
            lamp_q  <= lamp_d;
        end
    end

    assign {main_r, main_y, main_g, side_r, side_y, side_g} = lamp_q;
    assign state     = state_q;
    assign wr_strobe = strobe;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_ctrl
//  Description : Self-checking bench for traffic_light_ctrl. A cycle-count
//                model predicts every output each cycle; directed scenarios
//                pin dwell lengths, blink pattern, overrides and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int ALLRED_TICKS = 1;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       spi_wen;
    logic [1:0] spi_addr;
    logic [2:0] spi_data;
    logic       main_r, main_y, main_g, side_r, side_y, side_g;
    logic [2:0] state;
    logic       wr_strobe;

    int checks = 0;
    int passes = 0;

    traffic_light_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .ALLRED_TICKS(ALLRED_TICKS)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .spi_wen  (spi_wen),
        .spi_addr (spi_addr),
        .spi_data (spi_data),
        .main_r   (main_r),
        .main_y   (main_y),
        .main_g   (main_g),
        .side_r   (side_r),
        .side_y   (side_y),
        .side_g   (side_g),
        .state    (state),
        .wr_strobe(wr_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // State held as "which phase, how many cycles spent in it, how many
    // ticks it was granted on entry"; writes land on the 3rd edge after
    // the first edge that sees spi_wen high.
    int         m_st, m_cnt, m_dwell, m_cd;
    logic       m_last;
    logic [2:0] m_reg [4];

    function automatic int ticks_of(input logic [2:0] v);
        return (v == 3'd0) ? 8 : int'(v);
    endfunction

    function automatic int dur_of(input int s);
        case (s)
            1:       return ticks_of(m_reg[1]);
            4:       return ticks_of(m_reg[2]);
            2, 5:    return ticks_of(m_reg[3]);
            3, 6:    return ALLRED_TICKS;
            default: return 0;
        endcase
    endfunction

    function automatic int next_st(input int st, input int cnt, input int dw, input logic [2:0] c);
        if (c[2] || !c[0]) return 0;
        if (c[1]) return 7;
        if (st == 0) return 1;
        if (st == 7) return 0;
        if (cnt + 1 >= dw * TICK_DIV) return (st == 6) ? 1 : st + 1;
        return st;
    endfunction

    function automatic logic [5:0] lamps_of(input int st, input int cnt);
        logic p;
        p = ((cnt / TICK_DIV) % 2) == 0;
        case (st)
            1:       return 6'b001100;
            2:       return 6'b010100;
            4:       return 6'b100001;
            5:       return 6'b100010;
            7:       return {1'b0, p, 1'b0, 1'b0, p, 1'b0};
            default: return 6'b100100;
        endcase
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_st    <= 0;
            m_cnt   <= 0;
            m_dwell <= 0;
            m_cd    <= 0;
            m_last  <= 1'b0;
            m_reg[0] <= 3'd0;
            m_reg[1] <= 3'd5;
            m_reg[2] <= 3'd3;
            m_reg[3] <= 3'd2;
        end else begin
            if (next_st(m_st, m_cnt, m_dwell, m_reg[0]) != m_st) begin
                m_st    <= next_st(m_st, m_cnt, m_dwell, m_reg[0]);
                m_cnt   <= 0;
                m_dwell <= dur_of(next_st(m_st, m_cnt, m_dwell, m_reg[0]));
            end else begin
                m_cnt <= m_cnt + 1;
            end
            if (m_cd == 1) m_reg[spi_addr] <= spi_data;
            m_cd   <= (spi_wen && !m_last) ? 2 : ((m_cd > 0) ? m_cd - 1 : 0);
            m_last <= spi_wen;
        end
    end

    // Every-cycle comparison against the model, plus the lamp invariant
    always @(negedge clk) begin
        logic [9:0] act, exp;
        logic       inv_ok;
        act = {main_r, main_y, main_g, side_r, side_y, side_g, state, wr_strobe};
        exp = {lamps_of(m_st, m_cnt), 3'(m_st), (m_cd == 1)};
        chk("model_outputs", int'(act), int'(exp));
        inv_ok = !(main_g && side_g) &&
                 ($countones({main_r, main_y, main_g}) <= 1) &&
                 ($countones({side_r, side_y, side_g}) <= 1);
        chk("lamp_invariant", int'(inv_ok), 1);
    end

    // ---------------- directed helpers ----------------
    task automatic write_reg(input logic [1:0] a, input logic [2:0] d);
        @(negedge clk);
        #1;
        spi_addr = a;
        spi_data = d;
        spi_wen  = 1'b1;
        repeat (5) @(negedge clk);
        #1 spi_wen = 1'b0;
        @(negedge clk);
    endtask

    // Called on a negedge; counts cycles the current state persists
    task automatic dwell(output int s, output int n);
        s = int'(state);
        n = 0;
        while (int'(state) == s && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_state(input int s);
        int n;
        n = 0;
        while (int'(state) != s && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("wait_state_reached", int'(state), s);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s, n, k;
        int exp_st  [6] = '{1, 2, 3, 4, 5, 6};
        int exp_len [6] = '{20, 8, 4, 12, 8, 4};
        logic [15:0] vm, vs;

        n_rst    = 1'b0;
        spi_wen  = 1'b0;
        spi_addr = 2'd0;
        spi_data = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_lamps", int'({main_r, main_y, main_g, side_r, side_y, side_g}), 6'b100100);
        chk("reset_strobe", int'(wr_strobe), 0);
        #1 n_rst = 1'b1;

        // 1: run, write latency, then one full cycle of dwell lengths
        @(negedge clk);
        #1;
        spi_addr = 2'd0;
        spi_data = 3'd1;
        spi_wen  = 1'b1;
        k = 0;
        while (k < 10 && state != 3'd1) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("run_latency_edges", k, 4);
        fork
            begin
                repeat (2) @(negedge clk);
                #1 spi_wen = 1'b0;
            end
        join_none
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            dwell(s, n);
            chk("cycle_state", s, exp_st[i]);
            chk("cycle_len", n, exp_len[i]);
        end

        // 2: MGRN=0 mid-green leaves this dwell alone, next green is 8 ticks
        fork
            write_reg(2'd1, 3'd0);
            dwell(s, n);
        join
        chk("mgrn_cur_state", s, 1);
        chk("mgrn_cur_len", n, 20);
        for (int i = 0; i < 5; i++) dwell(s, n);
        dwell(s, n);
        chk("mgrn0_state", s, 1);
        chk("mgrn0_len", n, 32);

        // 3: force_red during side green, then resume
        wait_state(4);
        write_reg(2'd0, 3'b101);
        chk("force_red_state", int'(state), 0);
        chk("force_red_lamps", int'({main_r, main_y, main_g, side_r, side_y, side_g}), 6'b100100);
        write_reg(2'd0, 3'b001);
        chk("resume_state", int'(state), 1);

        // 4: blink pattern, then exit through a single all-red cycle
        vm = '0;
        vs = '0;
        fork
            write_reg(2'd0, 3'b011);
            begin
                wait_state(7);
                for (int i = 0; i < 16; i++) begin
                    vm[i] = main_y;
                    vs[i] = side_y;
                    @(negedge clk);
                end
            end
        join
        chk("blink_main_y", int'(vm), 16'h0F0F);
        chk("blink_side_y", int'(vs), 16'h0F0F);
        fork
            write_reg(2'd0, 3'b001);
            begin
                n = 0;
                while (state == 3'd7 && n < 100) begin
                    n++;
                    @(negedge clk);
                end
                chk("blink_exit_idle", int'(state), 0);
                @(negedge clk);
                chk("blink_exit_green", int'(state), 1);
            end
        join

        // 5: held write strobes once; then reset mid side-yellow
        @(negedge clk);
        #1;
        spi_addr = 2'd2;
        spi_data = 3'd6;
        spi_wen  = 1'b1;
        k = 0;
        repeat (50) begin
            @(negedge clk);
            if (wr_strobe) k++;
        end
        #1 spi_wen = 1'b0;
        chk("held_wen_pulses", k, 1);
        wait_state(5);
        wait_state(4);
        dwell(s, n);
        chk("sgrn6_len", n, 24);
        wait_state(5);
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("async_reset_lamps", int'({main_r, main_y, main_g, side_r, side_y, side_g}), 6'b100100);
        chk("async_reset_state", int'(state), 0);
        @(negedge clk);
        #1 n_rst = 1'b1;
        write_reg(2'd0, 3'b001);
        wait_state(2);
        wait_state(4);
        dwell(s, n);
        chk("sgrn_after_reset_len", n, 12);
        wait_state(1);
        dwell(s, n);
        chk("mgrn_after_reset_len", n, 20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #2000000;
        checks++;
        $display("FAIL global_timeout: got running expected finished");
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Sequencer for a two-road intersection (main and side roads). Runs the lamp state machine and owns four 3-bit configuration registers. The registers are written over SPI through the spi_slave write port (wen/addr/data). That port sits in the spi_sclk domain, so this block synchronizes the write strobe into clk, decodes the write, and applies it to the timing and control of the lamp cycle.

Parameters:
TICK_DIV, 1000000, clk cycles per timing unit (tick); simulation uses 4.
ALLRED_TICKS, 1, ticks spent in each all-red clearance state (1..7).

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
spi_wen  input  1  write strobe from spi_slave (spi_sclk domain, level)
spi_addr  input  2  register address from spi_slave
spi_data  input  3  write data from spi_slave
main_r  output  1  main road red lamp
main_y  output  1  main road yellow lamp
main_g  output  1  main road green lamp
side_r  output  1  side road red lamp
side_y  output  1  side road yellow lamp
side_g  output  1  side road green lamp
state  output  3  current FSM state encoding
wr_strobe  output  1  one-cycle pulse when a config write is applied

Behaviour:
- Clock and reset: single clock clk. n_rst is asynchronous and active-low; all flops clear immediately on assertion.
- Reset values:
  - state=IDLE(0); wr_strobe=0.
  - Lamps: main_r=side_r=1, all other lamps 0.
  - Registers: CTRL=3'b000, MGRN=3'd5, SGRN=3'd3, YEL=3'd2.
  - Prescaler=0, timer=0, sync flops=0.
- Write path:
  - spi_wen passes through a 2-flop synchronizer into wen_s, then a delay flop wen_d.
  - wr_strobe = wen_s & ~wen_d, i.e. one pulse per spi_wen rising edge.
  - On the clk edge where wr_strobe=1, spi_addr/spi_data are captured into register[spi_addr]. Write latency is 3 clk edges from the first edge sampling spi_wen=1.
  - Upstream holds addr/data stable for at least 4 clk cycles after wen rises.
  - spi_wen held high produces exactly one write.
- Register map:
  - 0 CTRL: bit0 run, bit1 blink, bit2 force_red.
  - 1 MGRN: main green duration in ticks.
  - 2 SGRN: side green duration in ticks.
  - 3 YEL: yellow duration in ticks (both roads).
  - A duration value of 0 means 8 ticks.
- Timing registers are sampled only when a timed state is entered. A write mid-state does not alter the current dwell.
- Prescaler: counts 0..TICK_DIV-1 and asserts tick when it equals TICK_DIV-1. It is cleared on every state change, so dwell in a timed state = duration*TICK_DIV cycles exactly.
- Timer: loaded with the duration on state entry and decremented on tick. The state exits on the tick where timer==1.
- States (encoding) and lamps:
  - IDLE(0): both red.
  - M_GREEN(1): main_g, side_r.
  - M_YELLOW(2): main_y, side_r.
  - M_ALLRED(3): both red.
  - S_GREEN(4): side_g, main_r.
  - S_YELLOW(5): side_y, main_r.
  - S_ALLRED(6): both red.
  - BLINK(7): main_y=side_y=blink phase; all other lamps 0. Blink phase starts at 1 on entry and toggles each tick.
- Normal cycle: M_GREEN(MGRN) -> M_YELLOW(YEL) -> M_ALLRED(ALLRED_TICKS) -> S_GREEN(SGRN) -> S_YELLOW(YEL) -> S_ALLRED(ALLRED_TICKS) -> M_GREEN.
- Override priority, evaluated every cycle from the live CTRL value, highest first:
  1. force_red=1 -> IDLE next edge, from any state.
  2. run=0 -> IDLE next edge.
  3. blink=1 -> BLINK next edge, from any non-BLINK state.
  4. Otherwise the normal cycle.
- Exits from IDLE and BLINK:
  - IDLE -> M_GREEN on the edge after run=1, blink=0, force_red=0 is observed.
  - BLINK with blink cleared (run=1, force_red=0) -> IDLE -> M_GREEN (one cycle of all red).
- Lamps are registered outputs derived from the next state, so they change on the same edge as `state`.
- Invariant: at most one lamp per road is on, and main and side green are never on simultaneously.
- Reset mid-cycle returns to IDLE with all-red lamps and the register reset values; there is no resume.

Test Plan:
1. TICK_DIV=4, reset, write CTRL=1 -> state goes to 1 three edges after wen plus one. Then main_g holds 20 cycles, main_y 8, all-red 4, side_g 12, side_y 8, all-red 4, and the cycle repeats.
2. Write MGRN=0 during M_GREEN -> the current dwell is unchanged; the next M_GREEN lasts 32 cycles (8 ticks).
3. During S_GREEN write CTRL=3'b101 -> IDLE on the next edge with main_r=side_r=1; then write CTRL=1 -> M_GREEN.
4. Write CTRL=3 -> BLINK: main_y=side_y=1 for 4 cycles, 0 for 4, repeating. Then write CTRL=1 -> one IDLE cycle, then M_GREEN.
5. Hold spi_wen high 50 cycles with addr=2, data=6 -> exactly one wr_strobe pulse, SGRN=6; assert n_rst=0 mid-S_YELLOW -> lamps go all-red immediately and SGRN reads back as 3.
6. Every cycle of scenarios 1–5: assertion that no road has more than one lamp on and main_g&side_g is never 1.
